// File: rtl/dcache_assoc_wb.sv
// Write-back, write-allocate L1 data cache, 1- or 2-way set associative with LRU.
// Hits return data combinationally. A miss stalls the CPU while the FSM writes back
// a dirty victim (if any) and refills the line over the L2 burst port.
module dcache_assoc_wb #(
  parameter int SETS_LOG2  = 4,
  parameter int WORDS_LOG2 = 3,
  parameter int WAYS       = 2,
  localparam int TAG_W     = 30 - SETS_LOG2 - WORDS_LOG2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rreq,
  input  logic                       wreq,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  input  logic [3:0]                 wbe,
  output logic [31:0]                rdata,
  output logic                       miss,
  output logic                       l2_rreq,
  output logic                       l2_wreq,
  output logic [31:0]                l2_addr,
  output logic [4:0]                 l2_burst_size,
  output logic [31:0]                l2_wdata,
  input  logic [31:0]                l2_rdata,
  input  logic                       l2_busy,
  output logic [TAG_W+SETS_LOG2-1:0] invalid_line,
  output logic                       invalid_req
);

  localparam int SETS  = 1 << SETS_LOG2;
  localparam int WORDS = 1 << WORDS_LOG2;
  localparam int OFF_W = WORDS_LOG2 + 2;
  localparam logic [4:0] BURST = 5'(WORDS);
  localparam logic [WORDS_LOG2-1:0] LAST_WORD = WORDS_LOG2'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, WREQ, WBUSY, WRITE, RREQ, RBUSY, READ} state_t;

  state_t                 state_q;
  logic [WORDS_LOG2-1:0]  cnt_q;
  logic                   vic_q;

  logic [31:0]            data_mem [WAYS][SETS][WORDS];
  logic [TAG_W-1:0]       tag_mem  [WAYS][SETS];
  logic [SETS-1:0]        valid_q  [WAYS];
  logic [SETS-1:0]        dirty_q  [WAYS];
  logic [SETS-1:0]        mru_q;

  logic [TAG_W-1:0]       cpu_tag;
  logic [SETS_LOG2-1:0]   cpu_set;
  logic [WORDS_LOG2-1:0]  cpu_word;
  logic [31:0]            rd_line;
  logic [WAYS-1:0]        hit_way;
  logic                   hit;
  logic                   hit_idx;
  logic                   victim;
  logic                   cpu_req;
  logic                   unused_addr;

  assign cpu_tag     = addr[31 -: TAG_W];
  assign cpu_set     = addr[OFF_W +: SETS_LOG2];
  assign cpu_word    = addr[2 +: WORDS_LOG2];
  assign rd_line     = {cpu_tag, cpu_set, {OFF_W{1'b0}}};
  assign cpu_req     = rreq | wreq;
  assign unused_addr = ^addr[1:0];

  // Tag lookup across the ways and selection of the hit word.
  always_comb begin
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_way[w] = valid_q[w][cpu_set] && (tag_mem[w][cpu_set] == cpu_tag);
    end
    hit     = |hit_way;
    hit_idx = (WAYS == 2) ? hit_way[WAYS-1] : 1'b0;
    rdata   = data_mem[hit_idx][cpu_set][cpu_word];
    miss    = (state_q != IDLE) | (cpu_req & ~hit);
  end

  // Victim choice: first invalid way, otherwise the least recently used one.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!valid_q[0][cpu_set]) begin
        victim = 1'b0;
      end else if (!valid_q[WAYS-1][cpu_set]) begin
        victim = 1'b1;
      end else begin
        victim = ~mru_q[cpu_set];
      end
    end
  end

  // Miss-handling FSM plus all cache array and replacement-state updates.
  // The CPU holds addr during a miss, so set/tag come straight from it in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      vic_q         <= 1'b0;
      l2_rreq       <= 1'b0;
      l2_wreq       <= 1'b0;
      l2_addr       <= '0;
      l2_burst_size <= '0;
      l2_wdata      <= '0;
      invalid_line  <= '0;
      invalid_req   <= 1'b0;
      mru_q         <= '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      l2_rreq     <= 1'b0;
      l2_wreq     <= 1'b0;
      invalid_req <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            if (hit) begin
              if (WAYS == 2) mru_q[cpu_set] <= hit_idx;
              if (wreq) begin
                for (int unsigned b = 0; b < 4; b++) begin
                  if (wbe[b]) data_mem[hit_idx][cpu_set][cpu_word][8*b +: 8] <= wdata[8*b +: 8];
                end
                dirty_q[hit_idx][cpu_set] <= 1'b1;
              end
            end else begin
              vic_q         <= victim;
              l2_burst_size <= BURST;
              if (valid_q[victim][cpu_set] && dirty_q[victim][cpu_set]) begin
                l2_wreq <= 1'b1;
                l2_addr <= {tag_mem[victim][cpu_set], cpu_set, {OFF_W{1'b0}}};
                state_q <= WREQ;
              end else begin
                l2_rreq                  <= 1'b1;
                l2_addr                  <= rd_line;
                valid_q[victim][cpu_set] <= 1'b0;
                state_q                  <= RREQ;
              end
            end
          end
        end
        WREQ: state_q <= WBUSY;
        WBUSY: begin
          if (!l2_busy) begin
            l2_wdata <= data_mem[vic_q][cpu_set][0];
            cnt_q    <= WORDS_LOG2'(1);
            state_q  <= WRITE;
          end
        end
        WRITE: begin
          // cnt wraps to zero once the last word has been placed on l2_wdata
          if (cnt_q == '0) begin
            invalid_req             <= 1'b1;
            invalid_line            <= {tag_mem[vic_q][cpu_set], cpu_set};
            l2_rreq                 <= 1'b1;
            l2_addr                 <= rd_line;
            valid_q[vic_q][cpu_set] <= 1'b0;
            state_q                 <= RREQ;
          end else begin
            l2_wdata <= data_mem[vic_q][cpu_set][cnt_q];
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        RREQ: begin
          tag_mem[vic_q][cpu_set] <= cpu_tag;
          state_q                 <= RBUSY;
        end
        RBUSY: begin
          if (!l2_busy) begin
            data_mem[vic_q][cpu_set][0] <= l2_rdata;
            cnt_q                       <= WORDS_LOG2'(1);
            state_q                     <= READ;
          end
        end
        READ: begin
          data_mem[vic_q][cpu_set][cnt_q] <= l2_rdata;
          if (cnt_q == LAST_WORD) begin
            valid_q[vic_q][cpu_set] <= 1'b1;
            dirty_q[vic_q][cpu_set] <= 1'b0;
            if (WAYS == 2) mru_q[cpu_set] <= vic_q;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_assoc_wb.sv
// Scoreboard bench for dcache_assoc_wb: stimulus queues expected CPU read data,
// L2 requests, writeback words and invalidations; monitors pop and compare.
module tb_dcache_assoc_wb;

  localparam int SETS_LOG2  = 4;
  localparam int WORDS_LOG2 = 3;
  localparam int WAYS       = 2;
  localparam int TAG_W      = 30 - SETS_LOG2 - WORDS_LOG2;
  localparam int N          = 1 << WORDS_LOG2;

  logic clk, reset, rreq, wreq, miss, l2_rreq, l2_wreq, l2_busy, invalid_req;
  logic [31:0] addr, wdata, rdata, l2_addr, l2_wdata, l2_rdata;
  logic [3:0]  wbe;
  logic [4:0]  l2_burst_size;
  logic [TAG_W+SETS_LOG2-1:0] invalid_line;

  dcache_assoc_wb #(.SETS_LOG2(SETS_LOG2), .WORDS_LOG2(WORDS_LOG2), .WAYS(WAYS)) dut (
    .clk(clk), .reset(reset), .rreq(rreq), .wreq(wreq), .addr(addr), .wdata(wdata),
    .wbe(wbe), .rdata(rdata), .miss(miss), .l2_rreq(l2_rreq), .l2_wreq(l2_wreq),
    .l2_addr(l2_addr), .l2_burst_size(l2_burst_size), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_busy(l2_busy), .invalid_line(invalid_line),
    .invalid_req(invalid_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [31:0] line; } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_wdata[$];
  logic [TAG_W+SETS_LOG2-1:0] exp_inv[$];
  logic [32:0] exp_cpu[$];
  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [31:0] l2_word(input logic [31:0] line, input int k);
    if (line == 32'h100) return 32'hA0 + 32'(k);
    return 32'hD000_0000 | (line + 32'(4 * k));
  endfunction

  // L2 model: checks each request and serves/collects its data burst
  initial begin
    l2_busy  = 1'b1;
    l2_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset && (l2_rreq || l2_wreq)) begin
        logic [31:0] line;
        line = l2_addr;
        if (exp_req.size() == 0) unexpected("l2_req_unexpected");
        else begin
          req_t e;
          e = exp_req.pop_front();
          check("l2_req_is_write", {63'd0, l2_wreq}, {63'd0, e.wr});
          check("l2_addr", {32'd0, l2_addr}, {32'd0, e.line});
        end
        check("l2_burst_size", {59'd0, l2_burst_size}, 64'd8);
        if (l2_wreq) begin
          repeat (busy_cycles + 1) @(posedge clk);
          #1 l2_busy = 1'b0;
          @(posedge clk); #1 l2_busy = 1'b1;
          for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (reset) break;
            if (exp_wdata.size() == 0) unexpected("l2_wdata_unexpected");
            else check($sformatf("l2_wdata_w%0d", k), {32'd0, l2_wdata}, {32'd0, exp_wdata.pop_front()});
          end
        end else begin
          repeat (busy_cycles + 1) @(posedge clk);
          #1 l2_busy = 1'b0;
          l2_rdata = l2_word(line, 0);
          for (int k = 1; k < N; k++) begin
            @(posedge clk); #1 l2_rdata = l2_word(line, k);
          end
          @(posedge clk); #1 l2_busy = 1'b1;
        end
      end
    end
  end

  // CPU-side monitor: a completed read must return the queued word
  always @(negedge clk) begin
    if (!reset && (rreq || wreq) && !miss) begin
      if (exp_cpu.size() == 0) unexpected("cpu_completion_unexpected");
      else begin
        logic [32:0] e;
        e = exp_cpu.pop_front();
        if (!e[32]) check("rdata", {32'd0, rdata}, {32'd0, e[31:0]});
      end
    end
  end

  // Invalidation monitor
  always @(negedge clk) begin
    if (!reset && invalid_req) begin
      if (exp_inv.size() == 0) unexpected("invalid_req_unexpected");
      else check("invalid_line", 64'(invalid_line), 64'(exp_inv.pop_front()));
    end
  end

  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic exp_miss, input logic [31:0] exp_rd);
    int n;
    exp_cpu.push_back({w, exp_rd});
    @(posedge clk); #1;
    rreq = r; wreq = w; addr = a; wdata = wd; wbe = be;
    @(negedge clk);
    check($sformatf("miss_first_%0h", a), {63'd0, miss}, {63'd0, exp_miss});
    n = 0;
    while (miss && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (miss) unexpected("miss_timeout");
    @(posedge clk); #1;
    rreq = 1'b0; wreq = 1'b0;
  endtask

  task automatic read_miss(input logic [31:0] a, input logic [31:0] line, input logic [31:0] exp_rd);
    exp_req.push_back('{1'b0, line});
    access(1'b1, 1'b0, a, 32'd0, 4'h0, 1'b1, exp_rd);
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_miss"}, {63'd0, miss}, 64'd0);
    check({pfx, "_l2_rreq"}, {63'd0, l2_rreq}, 64'd0);
    check({pfx, "_l2_wreq"}, {63'd0, l2_wreq}, 64'd0);
    check({pfx, "_invalid_req"}, {63'd0, invalid_req}, 64'd0);
    check({pfx, "_l2_addr"}, {32'd0, l2_addr}, 64'd0);
    check({pfx, "_l2_wdata"}, {32'd0, l2_wdata}, 64'd0);
    check({pfx, "_l2_burst_size"}, {59'd0, l2_burst_size}, 64'd0);
    check({pfx, "_invalid_line"}, 64'(invalid_line), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; rreq = 1'b0; wreq = 1'b0; addr = '0; wdata = '0; wbe = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_quiet("reset");

    // 1: cold read, refill, then a hit on the last word of the line
    busy_cycles = 2;
    read_miss(32'h100, 32'h100, 32'h0000_00A0);
    access(1'b1, 1'b0, 32'h11C, 32'd0, 4'h0, 1'b0, 32'h0000_00A7);

    // 2: partial byte write on a hit
    access(1'b0, 1'b1, 32'h104, 32'h1122_3344, 4'b0011, 1'b0, 32'd0);
    access(1'b1, 1'b0, 32'h104, 32'd0, 4'h0, 1'b0, 32'h0000_3344);

    // 6: simultaneous read+write acts as a write
    access(1'b1, 1'b1, 32'h108, 32'hCAFE_F00D, 4'hF, 1'b0, 32'd0);
    access(1'b1, 1'b0, 32'h108, 32'd0, 4'h0, 1'b0, 32'hCAFE_F00D);

    // 3: LRU replacement in set 3
    busy_cycles = 1;
    read_miss(32'h260, 32'h260, 32'hD000_0260);
    read_miss(32'h460, 32'h460, 32'hD000_0460);
    access(1'b1, 1'b0, 32'h260, 32'd0, 4'h0, 1'b0, 32'hD000_0260);
    read_miss(32'h660, 32'h660, 32'hD000_0660);
    access(1'b1, 1'b0, 32'h260, 32'd0, 4'h0, 1'b0, 32'hD000_0260);
    access(1'b1, 1'b0, 32'h664, 32'd0, 4'h0, 1'b0, 32'hD000_0664);
    read_miss(32'h460, 32'h460, 32'hD000_0460);

    // 4: dirty eviction of line 0x100 from set 8
    read_miss(32'h300, 32'h300, 32'hD000_0300);
    exp_req.push_back('{1'b1, 32'h100});
    exp_wdata.push_back(32'h0000_00A0);
    exp_wdata.push_back(32'h0000_3344);
    exp_wdata.push_back(32'hCAFE_F00D);
    for (int k = 3; k < N; k++) exp_wdata.push_back(32'hA0 + 32'(k));
    exp_inv.push_back(27'h8);
    read_miss(32'h500, 32'h500, 32'hD000_0500);

    // 5: reset in the middle of a writeback burst
    access(1'b0, 1'b1, 32'h300, 32'h5566_7788, 4'b1100, 1'b0, 32'd0);
    access(1'b1, 1'b0, 32'h500, 32'd0, 4'h0, 1'b0, 32'hD000_0500);
    busy_cycles = 0;
    exp_req.push_back('{1'b1, 32'h300});
    exp_wdata.push_back(32'h5566_0300);
    exp_wdata.push_back(32'hD000_0304);
    exp_wdata.push_back(32'hD000_0308);
    @(posedge clk); #1;
    rreq = 1'b1; addr = 32'h700;
    n = 0;
    while (!l2_wreq && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!l2_wreq) unexpected("wreq_timeout");
    repeat (5) @(posedge clk);
    #1 reset = 1'b1; rreq = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_quiet("midburst_reset");
    read_miss(32'h500, 32'h500, 32'hD000_0500);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("exp_req_left", 64'(exp_req.size()), 64'd0);
    check("exp_wdata_left", 64'(exp_wdata.size()), 64'd0);
    check("exp_inv_left", 64'(exp_inv.size()), 64'd0);
    check("exp_cpu_left", 64'(exp_cpu.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
